triangle_raster: RTL

//  Parametrised successor of the single-triangle pixel scanner. Accepts one screen-space triangle
//  (three packed {x,y} vertices) over a valid/ready handshake. Scans the triangle's bounding box,

---
 rtl/raster_pkg.sv | 17 +
 rtl/raster_edge_setup.sv | 77 +++++++
 rtl/triangle_raster.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: shared types and width helpers for the triangle rasteriser
package raster_pkg;

  localparam int CW = 10;

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} raster_state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vertex_t;

  function automatic int edge_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

endpackage

// File: rtl/raster_edge_setup.sv
// raster_edge_setup: clipped bounding box, edge values at the box origin, steps and doubled area
module raster_edge_setup
  import raster_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int WIDTH   = 1024,
  parameter int HEIGHT  = 720,
  localparam int EW     = edge_w(COORD_W)
) (
  input  logic [2*COORD_W-1:0] va,
  input  logic [2*COORD_W-1:0] vb,
  input  logic [2*COORD_W-1:0] vc,
  output logic [COORD_W-1:0]   xmin,
  output logic [COORD_W-1:0]   ymin,
  output logic [COORD_W-1:0]   xmax,
  output logic [COORD_W-1:0]   ymax,
  output logic signed [EW-1:0] e0,
  output logic signed [EW-1:0] e1,
  output logic signed [EW-1:0] e2,
  output logic signed [EW-1:0] dx0,
  output logic signed [EW-1:0] dx1,
  output logic signed [EW-1:0] dx2,
  output logic signed [EW-1:0] dy0,
  output logic signed [EW-1:0] dy1,
  output logic signed [EW-1:0] dy2,
  output logic signed [EW-1:0] area,
  output logic                 degen
);

  localparam logic [COORD_W:0] XLIM = (COORD_W+1)'(WIDTH - 1);
  localparam logic [COORD_W:0] YLIM = (COORD_W+1)'(HEIGHT - 1);

  logic [COORD_W-1:0] ax, ay, bx, by, cx, cy, xhi, yhi;

  function automatic logic signed [EW-1:0] sg(input logic [COORD_W-1:0] v);
    return $signed({{(EW-COORD_W){1'b0}}, v});
  endfunction

  // Edge p->q evaluated at t; positive on the left for counter-clockwise winding
  function automatic logic signed [EW-1:0] ed(input logic [COORD_W-1:0] px, py, qx, qy, tx, ty);
    return (sg(qx) - sg(px)) * (sg(ty) - sg(py)) - (sg(qy) - sg(py)) * (sg(tx) - sg(px));
  endfunction

  function automatic logic [COORD_W-1:0] mn3(input logic [COORD_W-1:0] a, b, c);
    return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction

  function automatic logic [COORD_W-1:0] mx3(input logic [COORD_W-1:0] a, b, c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction

  assign {ax, ay} = va;
  assign {bx, by} = vb;
  assign {cx, cy} = vc;

  assign xmin = mn3(ax, bx, cx);
  assign ymin = mn3(ay, by, cy);
  assign xhi  = mx3(ax, bx, cx);
  assign yhi  = mx3(ay, by, cy);
  assign xmax = ({1'b0, xhi} > XLIM) ? XLIM[COORD_W-1:0] : xhi;
  assign ymax = ({1'b0, yhi} > YLIM) ? YLIM[COORD_W-1:0] : yhi;

  assign e0   = ed(ax, ay, bx, by, xmin, ymin);
  assign e1   = ed(bx, by, cx, cy, xmin, ymin);
  assign e2   = ed(cx, cy, ax, ay, xmin, ymin);
  assign area = ed(ax, ay, bx, by, cx, cy);

  assign dx0 = sg(ay) - sg(by);
  assign dx1 = sg(by) - sg(cy);
  assign dx2 = sg(cy) - sg(ay);
  assign dy0 = sg(bx) - sg(ax);
  assign dy1 = sg(cx) - sg(bx);
  assign dy2 = sg(ax) - sg(cx);

  assign degen = (area == 0) || ({1'b0, xmin} > XLIM) || ({1'b0, ymin} > YLIM);

endmodule

// File: rtl/triangle_raster.sv
// triangle_raster: scans a triangle's clipped bounding box LANES pixels per cycle into mask beats
module triangle_raster
  import raster_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int WIDTH   = 1024,
  parameter int HEIGHT  = 720,
  parameter int LANES   = 4,
  localparam int EW     = edge_w(COORD_W),
  localparam int SH     = $clog2(LANES)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 tri_valid_in,
  output logic                 tri_ready_out,
  input  logic [2*COORD_W-1:0] vertex_a_in,
  input  logic [2*COORD_W-1:0] vertex_b_in,
  input  logic [2*COORD_W-1:0] vertex_c_in,
  output logic                 pix_valid_out,
  input  logic                 pix_ready_in,
  output logic [COORD_W-1:0]   pix_x_out,
  output logic [COORD_W-1:0]   pix_y_out,
  output logic [LANES-1:0]     pix_mask_out,
  output logic                 pix_last_out,
  output logic                 busy_out
);

  raster_state_t state;
  logic [2*COORD_W-1:0] va, vb, vc;
  logic [COORD_W-1:0] x, y, xmin, xmax, ymax;
  logic [COORD_W-1:0] s_xmin, s_ymin, s_xmax, s_ymax;
  logic signed [EW-1:0] e0, e1, e2, r0, r1, r2, dx0, dx1, dx2, dy0, dy1, dy2;
  logic signed [EW-1:0] s_e0, s_e1, s_e2, s_dx0, s_dx1, s_dx2, s_dy0, s_dy1, s_dy2, s_area;
  logic signed [EW-1:0] a0, a1, a2;
  logic s_degen, neg, adv, wrap, fin;
  logic [LANES-1:0] mask;

  raster_edge_setup #(.COORD_W(COORD_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_setup (
    .va(va), .vb(vb), .vc(vc),
    .xmin(s_xmin), .ymin(s_ymin), .xmax(s_xmax), .ymax(s_ymax),
    .e0(s_e0), .e1(s_e1), .e2(s_e2),
    .dx0(s_dx0), .dx1(s_dx1), .dx2(s_dx2),
    .dy0(s_dy0), .dy1(s_dy1), .dy2(s_dy2),
    .area(s_area), .degen(s_degen)
  );

  assign adv  = !pix_valid_out || pix_ready_in;
  assign wrap = ({1'b0, x} + (COORD_W+1)'(LANES)) > {1'b0, xmax};
  assign fin  = wrap && (y == ymax);

  // Lane inside test: edge values walk across the group by repeated dX adds; zero counts as inside
  always_comb begin
    a0 = e0;
    a1 = e1;
    a2 = e2;
    mask = '0;
    for (int k = 0; k < LANES; k++) begin
      mask[k] = ({1'b0, x} + (COORD_W+1)'(k) <= {1'b0, xmax}) &&
                (neg ? (a0 <= 0 && a1 <= 0 && a2 <= 0) : (a0 >= 0 && a1 >= 0 && a2 >= 0));
      a0 = a0 + dx0;
      a1 = a1 + dx1;
      a2 = a2 + dx2;
    end
  end

  // Control FSM plus scan state and the registered output beat
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      tri_ready_out <= 1'b0;
      busy_out <= 1'b0;
      pix_valid_out <= 1'b0;
      pix_x_out <= '0;
      pix_y_out <= '0;
      pix_mask_out <= '0;
      pix_last_out <= 1'b0;
      {va, vb, vc} <= '0;
      {x, y, xmin, xmax, ymax} <= '0;
      {e0, e1, e2, r0, r1, r2} <= '0;
      {dx0, dx1, dx2, dy0, dy1, dy2} <= '0;
      neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tri_ready_out <= 1'b1;
          if (tri_valid_in && tri_ready_out) begin
            va <= vertex_a_in;
            vb <= vertex_b_in;
            vc <= vertex_c_in;
            tri_ready_out <= 1'b0;
            busy_out <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          x <= s_xmin;
          y <= s_ymin;
          xmin <= s_xmin;
          xmax <= s_xmax;
          ymax <= s_ymax;
          {e0, e1, e2} <= {s_e0, s_e1, s_e2};
          {r0, r1, r2} <= {s_e0, s_e1, s_e2};
          {dx0, dx1, dx2} <= {s_dx0, s_dx1, s_dx2};
          {dy0, dy1, dy2} <= {s_dy0, s_dy1, s_dy2};
          neg <= s_area < 0;
          if (s_degen) begin
            pix_valid_out <= 1'b1;
            pix_x_out <= '0;
            pix_y_out <= '0;
            pix_mask_out <= '0;
            pix_last_out <= 1'b1;
            state <= DRAIN;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (adv) begin
            pix_valid_out <= (|mask) || fin;
            pix_x_out <= x;
            pix_y_out <= y;
            pix_mask_out <= mask;
            pix_last_out <= fin;
            if (fin) begin
              state <= DRAIN;
            end else if (wrap) begin
              x <= xmin;
              y <= y + COORD_W'(1);
              {e0, e1, e2} <= {r0 + dy0, r1 + dy1, r2 + dy2};
              {r0, r1, r2} <= {r0 + dy0, r1 + dy1, r2 + dy2};
            end else begin
              x <= x + COORD_W'(LANES);
              {e0, e1, e2} <= {e0 + (dx0 <<< SH), e1 + (dx1 <<< SH), e2 + (dx2 <<< SH)};
            end
          end
        end
        DRAIN: begin
          if (pix_ready_in) begin
            pix_valid_out <= 1'b0;
            tri_ready_out <= 1'b1;
            busy_out <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
